// File: rtl/passcode_entry_ctrl.sv
// passcode_entry_ctrl: keypad lock sequencer; define LOCKOUT_EN for timed lockout after repeated failures
module passcode_entry_ctrl #(
  parameter logic [15:0] DEFAULT_PW = 16'h1234
`ifdef LOCKOUT_EN
  , parameter int unsigned MAX_FAIL = 3
  , parameter logic [31:0] LOCKOUT_CYCLES = 32'd100_000_000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic        clear,
  input  logic        change,
  input  logic [3:0]  switch,
  output logic [15:0] entry_buf,
  output logic [1:0]  digit_idx,
  output logic [2:0]  state_code,
  output logic        unlocked,
  output logic [7:0]  led
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_NEW     = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;
  localparam logic [2:0] S_LOCKOUT = 3'd6;
  logic [2:0]  state, state_n;
  logic [15:0] pw, pw_n, buf_n, buf_ins;
  logic [1:0]  idx_n;
  logic        enter_q, clear_q, change_q;
  logic        clr_e, ent_e, chg_e;
`ifdef LOCKOUT_EN
  logic [2:0]  fail_cnt, fail_n;
  logic [31:0] cnt, cnt_n;
`endif
  assign state_code = state;
  // clear beats enter beats change; losers are dropped
  assign clr_e = clear & ~clear_q;
  assign ent_e = enter & ~enter_q & ~clr_e;
  assign chg_e = change & ~change_q & ~clr_e & ~ent_e;
  always_comb begin
    buf_ins = entry_buf;
    buf_ins[{~digit_idx, 2'b00} +: 4] = switch;
  end
  always_comb begin
    state_n = state;
    buf_n = entry_buf;
    idx_n = digit_idx;
    pw_n = pw;
`ifdef LOCKOUT_EN
    fail_n = fail_cnt;
    cnt_n = cnt;
`endif
    case (state)
      S_IDLE: if (ent_e) begin
        state_n = S_ENTRY;
        buf_n = '0;
        idx_n = '0;
      end
      S_ENTRY, S_NEW: if (clr_e) begin
        state_n = (state == S_NEW) ? S_OPEN : S_ENTRY;
        buf_n = (state == S_NEW) ? entry_buf : 16'h0;
        idx_n = (state == S_NEW) ? digit_idx : 2'd0;
      end else if (ent_e) begin
        buf_n = buf_ins;
        idx_n = (digit_idx == 2'd3) ? digit_idx : digit_idx + 2'd1;
        state_n = (digit_idx != 2'd3) ? state : (state == S_NEW) ? S_IDLE : S_CHECK;
        pw_n = (digit_idx == 2'd3 && state == S_NEW) ? buf_ins : pw;
      end
      S_CHECK: begin
`ifdef LOCKOUT_EN
        fail_n = (entry_buf == pw) ? 3'd0 : (fail_cnt == 3'd7) ? fail_cnt : fail_cnt + 3'd1;
        cnt_n = LOCKOUT_CYCLES - 32'd1;
        state_n = (entry_buf == pw) ? S_OPEN
                : (32'(fail_cnt) + 32'd1 >= MAX_FAIL) ? S_LOCKOUT : S_FAIL;
`else
        state_n = (entry_buf == pw) ? S_OPEN : S_FAIL;
`endif
      end
      S_OPEN: if (chg_e) begin
        state_n = S_NEW;
        buf_n = '0;
        idx_n = '0;
      end else if (ent_e) state_n = S_IDLE;
      S_FAIL: if (clr_e | ent_e) state_n = S_IDLE;
`ifdef LOCKOUT_EN
      S_LOCKOUT: begin
        state_n = (cnt == 32'd0) ? S_IDLE : S_LOCKOUT;
        fail_n = (cnt == 32'd0) ? 3'd0 : fail_cnt;
        cnt_n = (cnt == 32'd0) ? cnt : cnt - 32'd1;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pw <= DEFAULT_PW;
      entry_buf <= '0;
      digit_idx <= '0;
      enter_q <= 1'b0;
      clear_q <= 1'b0;
      change_q <= 1'b0;
      unlocked <= 1'b0;
      led <= '0;
    end else begin
      state <= state_n;
      pw <= pw_n;
      entry_buf <= buf_n;
      digit_idx <= idx_n;
      enter_q <= enter;
      clear_q <= clear;
      change_q <= change;
      unlocked <= state_n == S_OPEN;
      led <= {(state_n == S_ENTRY || state_n == S_NEW) ? 4'b0001 << idx_n : 4'b0000,
              state_n == S_LOCKOUT, state_n == S_NEW, state_n == S_FAIL, state_n == S_OPEN};
    end
  end
`ifdef LOCKOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_cnt <= '0;
      cnt <= '0;
    end else begin
      fail_cnt <= fail_n;
      cnt <= cnt_n;
    end
  end
`endif
endmodule
